// File: rtl/adc_capture.sv
// adc_capture
//   Receive side of the codec serial interface. Deserialises the left-channel
//   ADC word (adclrc low, MSB first on adcdat) into DATA_W-bit samples and
//   writes one sample per frame to the shared sample SRAM at incrementing
//   addresses while record is high. Stops after writing MAX_ADDR.
//
// Ports
//   bclk      codec bit clock, all logic on its rising edge
//   reset     asynchronous, active-high reset
//   record    1 = capture enabled; 0 = idle with the addr/data bus released
//   adclrc    codec ADC frame clock, low = left-channel phase
//   adcdat    codec ADC serial data, MSB first
//   addr      SRAM address, high-Z when record is low or reset is active
//   data      SRAM write data, high-Z when record is low or reset is active
//   write     SRAM write strobe, one bclk per sample
//   full      sticky: MAX_ADDR has been written, capture halted
//   short_fr  one-cycle pulse: frame ended before DATA_W bits arrived
module adc_capture #(
  parameter int unsigned              DATA_W   = 16,
  parameter int unsigned              ADDR_W   = 18,
  parameter logic [ADDR_W-1:0]        MAX_ADDR = 18'h3FFFF
) (
  input  logic              bclk,
  input  logic              reset,
  input  logic              record,
  input  logic              adclrc,
  input  logic              adcdat,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              write,
  output logic              full,
  output logic              short_fr
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SHIFT,
    S_WRITE,
    S_FULL
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_buffer, addr_buffer_n;
  logic [DATA_W-1:0]   shift_reg, shift_reg_n;
  logic [DATA_W-1:0]   hold_reg, hold_reg_n;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic                lrc_d;
  logic                full_q, full_n;
  logic                short_q, short_n;
  logic                fall;
  logic [DATA_W-1:0]   shifted;
  logic                drive;

  assign fall    = lrc_d & ~adclrc;
  assign shifted = {shift_reg[DATA_W-2:0], adcdat};

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      addr_buffer <= '0;
      shift_reg   <= '0;
      hold_reg    <= '0;
      bit_cnt     <= '0;
      lrc_d       <= 1'b1;
      full_q      <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state       <= state_n;
      addr_buffer <= addr_buffer_n;
      shift_reg   <= shift_reg_n;
      hold_reg    <= hold_reg_n;
      bit_cnt     <= bit_cnt_n;
      lrc_d       <= adclrc;
      full_q      <= full_n;
      short_q     <= short_n;
    end
  end

  always_comb begin
    state_n       = state;
    addr_buffer_n = addr_buffer;
    shift_reg_n   = shift_reg;
    hold_reg_n    = hold_reg;
    bit_cnt_n     = bit_cnt;
    full_n        = full_q;
    short_n       = 1'b0;

    if (!record) begin
      // Any partial word is dropped; addr_buffer and full are held until the
      // next record rise clears them.
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          addr_buffer_n = '0;
          full_n        = 1'b0;
          state_n       = S_ARM;
        end
        S_ARM: begin
          // Only a fresh falling edge of adclrc starts a word, so arming in
          // the middle of a low phase waits for the next frame.
          if (fall) begin
            shift_reg_n = shifted;
            bit_cnt_n   = CNT_W'(1);
            state_n     = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (adclrc) begin
            bit_cnt_n = '0;
            short_n   = 1'b1;
            state_n   = S_ARM;
          end else begin
            shift_reg_n = shifted;
            bit_cnt_n   = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              hold_reg_n = shifted;
              state_n    = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (addr_buffer == MAX_ADDR) begin
            full_n  = 1'b1;
            state_n = S_FULL;
          end else begin
            addr_buffer_n = addr_buffer + ADDR_W'(1);
            state_n       = S_ARM;
          end
        end
        S_FULL: begin
          state_n = S_FULL;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // write is gated by record directly so that a record drop between edges
  // truncates the strobe immediately and the strobe never outlives the bus.
  assign drive    = record & ~reset;
  assign write    = (state == S_WRITE) & record;
  assign addr     = drive ? addr_buffer : 'z;
  assign data     = drive ? hold_reg : 'z;
  assign full     = full_q;
  assign short_fr = short_q;

endmodule
